wind_conditioner: RTL

WIND_CONDITIONER -- requirements
Module: wind_conditioner

---
 rtl/wind_pkg.sv | 11 +
 rtl/wind_conditioner_if.sv | 16 +
 rtl/sync_2ff.sv | 24 ++
 rtl/wind_conditioner.sv | 104 ++++++++++
 4 files changed

// File: rtl/wind_pkg.sv
// Shared wind-code definitions for the wind conditioner and the runway-light FSM.
package wind_pkg;

   typedef enum logic [1:0] {
      CALM = 2'b00,
      RTL  = 2'b01,
      LTR  = 2'b10,
      BAD  = 2'b11
   } wind_t;

endpackage

// File: rtl/wind_conditioner_if.sv
// Bundle of the raw wind switches and the conditioned outputs of wind_conditioner.
// master: the side that supplies raw_w and consumes the conditioned wind.
// slave:  the conditioner itself.
interface wind_conditioner_if;
   import wind_pkg::*;

   logic [1:0] raw_w;
   wind_t      w;
   logic       w_chg;
   logic       err;
   logic       tick;

   modport master (output raw_w, input w, w_chg, err, tick);
   modport slave  (input raw_w, output w, w_chg, err, tick);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer (sync1 -> q) for asynchronous inputs, parameterised width.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] sync1;

   // Two register stages to resolve metastability before the value is used.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         q     <= '0;
      end else begin
         sync1 <= d;
         q     <= sync1;
      end
   end

endmodule

// File: rtl/wind_conditioner.sv
// Wind switch conditioner: synchronizes, debounces and validates the raw wind
// switches, flags stable illegal codes, and produces the step tick for the
// runway-light FSM.
// Optional feature: define WIND_TICK_EN to build the TICK_DIV tick divider;
// without it, tick is simply held high in every cycle after reset.
module wind_conditioner
   import wind_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TICK_DIV        = 8
) (
   input  logic                clk,
   input  logic                reset,
   wind_conditioner_if.slave   bus
);

   localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

   logic [1:0] sync2;
   wind_t      cand;
   logic [7:0] cnt;
   wind_t      w;
   logic       w_chg;
   logic       err;
   logic       tick;
   logic       stable;
   logic       chg_now;

   sync_2ff #(
      .WIDTH (2)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (bus.raw_w),
      .q     (sync2)
   );

   // A code is stable once the candidate has matched sync2 for the full window.
   assign stable  = (sync2 == cand) && (cnt == CNT_MAX);
   assign chg_now = stable && (cand != BAD) && (cand != w);

   // Candidate tracking, acceptance of stable legal codes and the sticky error.
   always_ff @(posedge clk) begin
      if (reset) begin
         cand  <= CALM;
         cnt   <= '0;
         w     <= CALM;
         w_chg <= 1'b0;
         err   <= 1'b0;
      end else begin
         if (sync2 != cand) begin
            cand <= wind_t'(sync2);
            cnt  <= '0;
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 8'd1;
         end
         w_chg <= chg_now;
         if (stable) begin
            if (cand == BAD) begin
               err <= 1'b1;
            end else begin
               w   <= cand;
               err <= 1'b0;
            end
         end
      end
   end

`ifdef WIND_TICK_EN
   localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

   logic [15:0] tcnt;

   // Free-running step divider, realigned to every wind change so the first
   // step after a change comes a full period later.
   always_ff @(posedge clk) begin
      if (reset) begin
         tcnt <= '0;
         tick <= 1'b0;
      end else if (chg_now) begin
         tcnt <= '0;
         tick <= 1'b0;
      end else begin
         tick <= (tcnt == TICK_LAST);
         tcnt <= (tcnt == TICK_LAST) ? 16'd0 : tcnt + 16'd1;
      end
   end
`else
   // No divider: the downstream FSM steps every cycle once out of reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         tick <= 1'b0;
      end else begin
         tick <= 1'b1;
      end
   end
`endif

   assign bus.w     = w;
   assign bus.w_chg = w_chg;
   assign bus.err   = err;
   assign bus.tick  = tick;

endmodule
